riscv_fetch_unit: RTL
=====================

// Module: riscv_fetch_unit
// PURPOSE
// - Decoupled instruction-fetch front end for the pipelined RV32I core; replaces the combinational f_pc/imemory path of the single-cycle core.
// - Issues sequential requests to a fixed-latency, in-order instruction memory and buffers returned words with their PCs in a fetch queue.
// - Delivers words to decode over a valid/ready handshake.
// - Handles redirects (branch/jump) by flushing the queue and discarding stale responses; supports halt for ecall.
// PARAMETERS
// - XLEN        32     datapath/address width
// - START_ADDR  32'h0  fetch PC after reset
// - FQ_DEPTH    4      fetch-queue entries; power of 2, >=2
// - IMEM_LAT    1      fixed imem request->response latency in cycles, 1..4
// PORTS
// - clk             in   1        clock; all state updates on posedge
// - rst             in   1        reset; asynchronous, active-high
// - imem_req_valid  out  1        request valid
// - imem_req_ready  in   1        imem accepts the request this cycle
// - imem_req_addr   out  XLEN     word-aligned fetch address
// - imem_rsp_valid  in   1        response valid; arrives exactly IMEM_LAT cycles after the accepted request, in order
// - imem_rsp_data   in   32       instruction word
// - redirect_valid  in   1        redirect fetch to redirect_pc; highest priority
// - redirect_pc     in   XLEN     new PC; bits [1:0] ignored, treated as 0
// - halt_req        in   1        stop issuing requests (ecall)
// - halted          out  1        no requests outstanding, fetch stopped
// - out_valid       out  1        queue head valid
// - out_ready       in   1        decode accepts the head
// - out_pc          out  XLEN     PC of the head word
// - out_insn        out  32       head instruction word
// - fq_count        out  $clog2(FQ_DEPTH)+1  current queue occupancy
// BEHAVIOUR
// - Reset values: fetch_pc=START_ADDR, rsp_pc=START_ADDR, queue empty, inflight=0, drop_cnt=0, FSM=RUN.
// - Reset output values: imem_req_valid=0, out_valid=0, halted=0, fq_count=0.
// - Reset asserted mid-operation clears all state immediately. Responses that arrive after reset deasserts are counted against drop_cnt=0 and are therefore accepted.
//   Integration requirement: imem is held in reset with this block.
// - Issue rule: imem_req_valid = (FSM==RUN) && !redirect_valid && (fq_count + inflight < FQ_DEPTH).
//   This credit rule guarantees the queue never overflows. On accept: fetch_pc += 4; inflight += 1.
// - inflight update: inflight decrements on every imem_rsp_valid. A simultaneous issue and response leaves inflight unchanged.
// - Response handling:
//   - drop_cnt>0: discard the word, drop_cnt -= 1.
//   - Otherwise: push {rsp_pc, data} into the queue and set rsp_pc += 4.
// - Output: out_valid = (fq_count!=0) && !redirect_valid. Pop on out_valid && out_ready.
//   - Simultaneous push and pop keeps the count unchanged.
//   - A push into a full queue is impossible by construction; an assertion checks it.
// - Redirect cycle:
//   - Queue flushed (count=0); any pop that cycle is discarded.
//   - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b0}.
//   - drop_cnt = inflight minus 1 if a response is arriving this cycle, otherwise inflight. The arriving response is itself dropped.
//   - FSM -> RUN, overriding any halt.
// - Latency:
//   - Redirect at cycle t: request at t+1, response at t+1+IMEM_LAT, out_valid at t+2+IMEM_LAT.
//   - Steady state: one word per cycle when FQ_DEPTH > IMEM_LAT+1.
// - FSM transitions:
//   - RUN -> HALTING on halt_req.
//   - HALTING -> HALTED when inflight==0 and no request is being issued.
//   - HALTED -> RUN only on redirect_valid.
//   - halted=1 in HALTED only. The queue still drains to decode while HALTING or HALTED.
// - Arithmetic: PC increments wrap modulo 2^XLEN. inflight and drop_cnt are $clog2(FQ_DEPTH)+1 bits and never exceed FQ_DEPTH.
// STRUCTURE
// - riscv_pkg:
//   - XLEN, START_ADDR, INSN_NOP (32'h00000013).
//   - fetch_entry_t struct {pc, insn}.
//   - fetch_state_t enum {RUN, HALTING, HALTED}.
//   - Core optype index localparams (R..J_jal), shared with decode.
// - Sub-module fetch_queue:
//   - Parametrised synchronous FIFO of fetch_entry_t with push, pop, flush and count.
//   - Same asynchronous active-high reset.
// - Top level holds the PC registers, credit/drop counters and FSM.
// TESTING
// - Reset, then imem_req_ready=1 and out_ready=1, IMEM_LAT=1:
//   - Requests 0x0,0x4,0x8 on consecutive cycles.
//   - out_pc 0x0 with out_valid at cycle 3 after reset release, then 0x4, 0x8 back-to-back.
// - out_ready=0 with FQ_DEPTH=4:
//   - Exactly 4 requests issued, then imem_req_valid stays 0 and fq_count=4.
//   - Raise out_ready: 4 words drain in order, fetching resumes.
// - IMEM_LAT=3, redirect to 0x100 while 3 requests are in flight:
//   - The 3 stale responses are discarded.
//   - First out_pc=0x100 at t+5; no stale PC is ever presented.
// - Redirect in the same cycle as a response, an out_ready pop and halt_req:
//   - The response is dropped, the pop is ignored and the FSM stays RUN.
//   - Next request address = redirect target.
// - halt_req with 2 in flight:
//   - HALTING until both responses return, then halted=1 and no further requests.
//   - Redirect to 0x40 clears halted; fetch restarts at 0x40.
// - Assert rst mid-stream with the queue half full:
//   - Outputs clear immediately.
//   - After release, fetch restarts at START_ADDR with fq_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, reset PC, fetch entry and fetch FSM
// state types, and the optype indices that decode also uses.
package riscv_pkg;

    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] START_ADDR = 32'h0000_0000;
    localparam logic [31:0]     INSN_NOP   = 32'h0000_0013;

    // One buffered fetch result: the word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    // Instruction format / optype indices shared with decode.
    localparam int OPT_R       = 0;
    localparam int OPT_I_ALU   = 1;
    localparam int OPT_I_LOAD  = 2;
    localparam int OPT_I_JALR  = 3;
    localparam int OPT_S       = 4;
    localparam int OPT_B       = 5;
    localparam int OPT_U_LUI   = 6;
    localparam int OPT_U_AUIPC = 7;
    localparam int OPT_J_JAL   = 8;
    localparam int NUM_OPTYPES = 9;

    // Sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// Fetch queue: small synchronous FIFO of {pc, insn} entries with a
// single-cycle flush used on redirects.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    // Flush wins over any push or pop in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;
    assign head    = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    // The credit rule upstream must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled RV32I fetch front end: credit-limited sequential requests to a
// fixed-latency in-order imem, response buffering with PC tagging, redirect
// flush with stale-response dropping, and a halt FSM for ecall.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] START_ADDR = riscv_pkg::START_ADDR,
    parameter int              FQ_DEPTH   = 4,
    parameter int              IMEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [31:0]                 imem_rsp_data,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        halt_req,
    output logic                        halted,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [31:0]                 out_insn,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_used;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // The logic is purely credit based and never needs the memory latency;
    // the parameter documents the attached imem.
    logic [2:0]      unused_imem_lat;
    logic            unused_redirect_lsbs;
    assign unused_imem_lat      = 3'(IMEM_LAT);
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

    // Occupancy plus outstanding requests bounds the queue: every issued
    // request already owns a slot when its response lands.
    assign credit_used    = (CW+1)'(fq_count) + (CW+1)'(inflight);
    assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                            (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response is kept only if it is not stale and no redirect is flushing.
    assign push       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign push_entry = '{pc: rsp_pc, insn: imem_rsp_data};

    assign out_valid = (fq_count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head.pc;
    assign out_insn  = head.insn;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fq_count)
    );

    // Request and response PCs; both jump to the target on a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= START_ADDR;
            rsp_pc   <= START_ADDR;
        end else if (redirect_valid) begin
            fetch_pc <= target;
            rsp_pc   <= target;
        end else begin
            if (issue) fetch_pc <= pc_next(fetch_pc);
            if (push)  rsp_pc   <= pc_next(rsp_pc);
        end
    end

    // Outstanding-request credit and count of stale responses still to drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(imem_rsp_valid);
            if (redirect_valid)
                drop_cnt <= inflight - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Halt FSM; a redirect always restarts fetch, even over a halt request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) state <= HALTING;
                end
                HALTING: begin
                    if ((inflight == '0) && !issue) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
